// File: rtl/daisy_pkg.sv
// Shared definitions for the daisy-chain frame deframer: SOF marker, header layout,
// FSM encoding and status-counter width.
package daisy_pkg;

   localparam logic [15:0] DEF_SOF_WORD = 16'hA5C3;
   localparam int          CNT_W        = 16;

   localparam int HDR_TYPE_MSB = 15;
   localparam int HDR_TYPE_LSB = 12;
   localparam int HDR_SEQ_MSB  = 11;
   localparam int HDR_SEQ_LSB  = 8;
   localparam int HDR_LEN_MSB  = 7;
   localparam int HDR_LEN_LSB  = 0;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HDR  = 2'd1;
   localparam logic [1:0] ST_PAY  = 2'd2;
   localparam logic [1:0] ST_CHK  = 2'd3;

   typedef struct packed {
      logic [3:0] typ;
      logic [3:0] seq;
      logic [7:0] len;
   } hdr_t;

   function automatic hdr_t hdr_unpack(input logic [15:0] w);
      hdr_t h;
      h.typ = w[HDR_TYPE_MSB:HDR_TYPE_LSB];
      h.seq = w[HDR_SEQ_MSB:HDR_SEQ_LSB];
      h.len = w[HDR_LEN_MSB:HDR_LEN_LSB];
      return h;
   endfunction

endpackage

// File: rtl/daisy_sat_cnt.sv
// Saturating status counter; a clear always beats a coincident increment.
module daisy_sat_cnt
   import daisy_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/red_pitaya_daisy_deframer.sv
// Deframes SOF/header/payload/checksum words from the daisy RX into a payload stream
// with frame-result strobes and saturating status counters.
//   state | meaning
//   IDLE  | hunting for SOF_WORD
//   HDR   | next valid word is the header
//   PAY   | forwarding payload, summing, counting down
//   CHK   | next valid word is the checksum
module red_pitaya_daisy_deframer
   import daisy_pkg::*;
#(
   parameter logic [15:0] SOF_WORD    = DEF_SOF_WORD,
   parameter int          TIMEOUT_CYC = 64
) (
   input  logic              par_clk_i,
   input  logic              par_rst_i,
   input  logic              cfg_en_i,
   input  logic              cnt_clr_i,
   input  logic              par_dv_i,
   input  logic [15:0]       par_dat_i,
   output logic              out_dv_o,
   output logic [15:0]       out_dat_o,
   output logic              out_last_o,
   output logic [3:0]        out_type_o,
   output logic              frm_good_o,
   output logic              frm_bad_o,
   output logic              frm_abort_o,
   output logic [CNT_W-1:0]  cnt_frm_o,
   output logic [CNT_W-1:0]  cnt_chk_o,
   output logic [CNT_W-1:0]  cnt_seq_o,
   output logic [CNT_W-1:0]  cnt_err_o
);

   localparam int              GAP_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(TIMEOUT_CYC);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

   logic [1:0]       state_q, state_d;
   logic [3:0]       type_q, type_d;
   logic [7:0]       rem_q, rem_d;
   logic [15:0]      sum_q, sum_d;
   logic [3:0]       seq_prev_q, seq_prev_d;
   logic             seq_arm_q, seq_arm_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             out_dv_q, out_dv_d;
   logic [15:0]      out_dat_q, out_dat_d;
   logic             out_last_q, out_last_d;
   logic             good_q, good_d;
   logic             bad_q, bad_d;
   logic             abort_q, abort_d;
   logic             inc_frm, inc_chk, inc_seq, inc_err;
   logic [3:0]       seq_exp;
   hdr_t             hdr;

   assign hdr     = hdr_unpack(par_dat_i);
   assign seq_exp = seq_prev_q + 4'd1;

   always_comb begin
      state_d    = state_q;
      type_d     = type_q;
      rem_d      = rem_q;
      sum_d      = sum_q;
      seq_prev_d = seq_prev_q;
      seq_arm_d  = seq_arm_q;
      gap_d      = gap_q;
      out_dv_d   = 1'b0;
      out_dat_d  = out_dat_q;
      out_last_d = 1'b0;
      good_d     = 1'b0;
      bad_d      = 1'b0;
      abort_d    = 1'b0;
      inc_frm    = 1'b0;
      inc_chk    = 1'b0;
      inc_seq    = 1'b0;
      inc_err    = 1'b0;

      // Disarming the sequence check while disabled makes the first header after re-enable exempt.
      if (!cfg_en_i) begin
         state_d   = ST_IDLE;
         seq_arm_d = 1'b0;
      end else if (par_dv_i) begin
         gap_d = GAP_LOAD;
         case (state_q)
            ST_IDLE: begin
               if (par_dat_i == SOF_WORD)
                  state_d = ST_HDR;
            end
            ST_HDR: begin
               type_d     = hdr.typ;
               rem_d      = hdr.len;
               sum_d      = par_dat_i;
               seq_prev_d = hdr.seq;
               seq_arm_d  = 1'b1;
               if (seq_arm_q && (hdr.seq != seq_exp))
                  inc_seq = 1'b1;
               if (hdr.len == 8'd0) begin
                  state_d = ST_IDLE;
                  abort_d = 1'b1;
                  inc_err = 1'b1;
               end else begin
                  state_d = ST_PAY;
               end
            end
            ST_PAY: begin
               out_dv_d  = 1'b1;
               out_dat_d = par_dat_i;
               sum_d     = sum_q + par_dat_i;
               rem_d     = rem_q - 8'd1;
               if (rem_q == 8'd1) begin
                  out_last_d = 1'b1;
                  state_d    = ST_CHK;
               end
            end
            default: begin
               if (par_dat_i == sum_q) begin
                  good_d  = 1'b1;
                  inc_frm = 1'b1;
               end else begin
                  bad_d   = 1'b1;
                  inc_chk = 1'b1;
               end
               state_d = ST_IDLE;
            end
         endcase
      end else if (state_q != ST_IDLE) begin
         if (gap_q == GAP_ONE) begin
            state_d = ST_IDLE;
            abort_d = 1'b1;
            inc_err = 1'b1;
         end else begin
            gap_d = gap_q - GAP_ONE;
         end
      end
   end

   always_ff @(posedge par_clk_i) begin
      if (par_rst_i) begin
         state_q    <= ST_IDLE;
         type_q     <= '0;
         rem_q      <= '0;
         sum_q      <= '0;
         seq_prev_q <= '0;
         seq_arm_q  <= 1'b0;
         gap_q      <= '0;
         out_dv_q   <= 1'b0;
         out_dat_q  <= '0;
         out_last_q <= 1'b0;
         good_q     <= 1'b0;
         bad_q      <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         type_q     <= type_d;
         rem_q      <= rem_d;
         sum_q      <= sum_d;
         seq_prev_q <= seq_prev_d;
         seq_arm_q  <= seq_arm_d;
         gap_q      <= gap_d;
         out_dv_q   <= out_dv_d;
         out_dat_q  <= out_dat_d;
         out_last_q <= out_last_d;
         good_q     <= good_d;
         bad_q      <= bad_d;
         abort_q    <= abort_d;
      end
   end

   assign out_dv_o    = out_dv_q;
   assign out_dat_o   = out_dat_q;
   assign out_last_o  = out_last_q;
   assign out_type_o  = type_q;
   assign frm_good_o  = good_q;
   assign frm_bad_o   = bad_q;
   assign frm_abort_o = abort_q;

   daisy_sat_cnt #(.W(CNT_W)) u_cnt_frm (
      .clk_i(par_clk_i), .rst_i(par_rst_i), .clr_i(cnt_clr_i), .inc_i(inc_frm), .cnt_o(cnt_frm_o)
   );
   daisy_sat_cnt #(.W(CNT_W)) u_cnt_chk (
      .clk_i(par_clk_i), .rst_i(par_rst_i), .clr_i(cnt_clr_i), .inc_i(inc_chk), .cnt_o(cnt_chk_o)
   );
   daisy_sat_cnt #(.W(CNT_W)) u_cnt_seq (
      .clk_i(par_clk_i), .rst_i(par_rst_i), .clr_i(cnt_clr_i), .inc_i(inc_seq), .cnt_o(cnt_seq_o)
   );
   daisy_sat_cnt #(.W(CNT_W)) u_cnt_err (
      .clk_i(par_clk_i), .rst_i(par_rst_i), .clr_i(cnt_clr_i), .inc_i(inc_err), .cnt_o(cnt_err_o)
   );

endmodule

// File: tb/tb_red_pitaya_daisy_deframer.sv
// Bench for the daisy deframer: payload scoreboard plus per-scenario strobe/counter checks.
module tb_red_pitaya_daisy_deframer;
   import daisy_pkg::*;

   localparam logic [15:0] SOF = 16'hA5C3;
   localparam int          TMO = 64;

   logic        clk = 1'b0;
   logic        par_rst_i = 1'b1;
   logic        cfg_en_i = 1'b1;
   logic        cnt_clr_i = 1'b0;
   logic        par_dv_i = 1'b0;
   logic [15:0] par_dat_i = '0;
   logic        out_dv_o, out_last_o, frm_good_o, frm_bad_o, frm_abort_o;
   logic [15:0] out_dat_o;
   logic [3:0]  out_type_o;
   logic [15:0] cnt_frm_o, cnt_chk_o, cnt_seq_o, cnt_err_o;

   logic        sc_rst = 1'b1, sc_clr = 1'b0, sc_inc = 1'b0;
   logic [7:0]  sc_cnt;

   int checks = 0;
   int failures = 0;

   logic [16:0] exp_q[$];
   logic [15:0] pay_q[$];
   int          m_frm, m_chk, m_seq, m_err;
   logic [3:0]  m_prev;
   logic        m_armed;

   always #5 clk = ~clk;

   red_pitaya_daisy_deframer #(.SOF_WORD(SOF), .TIMEOUT_CYC(TMO)) dut (
      .par_clk_i(clk), .par_rst_i(par_rst_i), .cfg_en_i(cfg_en_i), .cnt_clr_i(cnt_clr_i),
      .par_dv_i(par_dv_i), .par_dat_i(par_dat_i), .out_dv_o(out_dv_o), .out_dat_o(out_dat_o),
      .out_last_o(out_last_o), .out_type_o(out_type_o), .frm_good_o(frm_good_o),
      .frm_bad_o(frm_bad_o), .frm_abort_o(frm_abort_o), .cnt_frm_o(cnt_frm_o),
      .cnt_chk_o(cnt_chk_o), .cnt_seq_o(cnt_seq_o), .cnt_err_o(cnt_err_o)
   );

   daisy_sat_cnt #(.W(8)) u_sc (
      .clk_i(clk), .rst_i(sc_rst), .clr_i(sc_clr), .inc_i(sc_inc), .cnt_o(sc_cnt)
   );

   // Payload scoreboard: every forwarded word must match the next expected {last, data}.
   always @(negedge clk) begin
      if (out_dv_o === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL payload_unexpected got=%h exp=none", {out_last_o, out_dat_o});
         end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            if ({out_last_o, out_dat_o} !== e) begin
               failures++;
               $display("FAIL payload got=%h exp=%h", {out_last_o, out_dat_o}, e);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic [15:0] d);
      @(negedge clk);
      par_dv_i  = 1'b1;
      par_dat_i = d;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         par_dv_i = 1'b0;
      end
   endtask

   task automatic model_hdr(input logic [3:0] seq);
      if (m_armed && (seq != 4'(m_prev + 4'd1))) m_seq++;
      m_prev  = seq;
      m_armed = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      par_rst_i = 1'b1;
      par_dv_i  = 1'b0;
      cnt_clr_i = 1'b0;
      cfg_en_i  = 1'b1;
      repeat (3) @(negedge clk);
      par_rst_i = 1'b0;
      exp_q.delete();
      m_frm = 0; m_chk = 0; m_seq = 0; m_err = 0; m_prev = 4'd0; m_armed = 1'b0;
   endtask

   task automatic send_frame(input logic [3:0] typ, input logic [3:0] seq,
                             input logic [15:0] corrupt, input logic clr_chk);
      logic [15:0] hdr, sum;
      int n;
      n   = pay_q.size();
      hdr = {typ, seq, 8'(n)};
      sum = hdr;
      drive(SOF);
      drive(hdr);
      model_hdr(seq);
      for (int i = 0; i < n; i++) begin
         logic last;
         last = (i == n - 1);
         sum  = sum + pay_q[i];
         exp_q.push_back({last, pay_q[i]});
         drive(pay_q[i]);
      end
      drive(sum + corrupt);
      if (clr_chk) begin
         cnt_clr_i = 1'b1;
         m_frm = 0; m_chk = 0; m_seq = 0; m_err = 0;
      end else if (corrupt != 16'd0) m_chk++;
      else m_frm++;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({out_dv_o, out_last_o, frm_good_o, frm_bad_o, frm_abort_o} !== 5'b0 ||
          out_dat_o !== 16'h0 || out_type_o !== 4'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%b/%h/%h exp=0",
                  {out_dv_o, out_last_o, frm_good_o, frm_bad_o, frm_abort_o}, out_dat_o, out_type_o);
      end
      checks++;
      if ({cnt_frm_o, cnt_chk_o, cnt_seq_o, cnt_err_o} !== 64'h0) begin
         failures++;
         $display("FAIL reset_counters got=%h exp=0", {cnt_frm_o, cnt_chk_o, cnt_seq_o, cnt_err_o});
      end
   endtask

   task automatic test_good_frame();
      pay_q = '{16'h0001, 16'h0002, 16'h0003};
      send_frame(4'h1, 4'h2, 16'h0, 1'b0);
      @(negedge clk); par_dv_i = 1'b0;
      checks++;
      if ({frm_good_o, frm_bad_o, frm_abort_o} !== 3'b100) begin
         failures++; $display("FAIL good_strobe got=%b exp=100", {frm_good_o, frm_bad_o, frm_abort_o});
      end
      checks++;
      if (out_type_o !== 4'h1) begin
         failures++; $display("FAIL good_type got=%h exp=1", out_type_o);
      end
      checks++;
      if (cnt_frm_o !== 16'd1) begin
         failures++; $display("FAIL good_cnt_frm got=%0d exp=1", cnt_frm_o);
      end
      @(negedge clk);
      checks++;
      if ({frm_good_o, frm_bad_o, frm_abort_o} !== 3'b000) begin
         failures++; $display("FAIL good_strobe_width got=%b exp=000", {frm_good_o, frm_bad_o, frm_abort_o});
      end
   endtask

   task automatic test_bad_checksum();
      pay_q = '{16'h0001, 16'h0002, 16'h0003};
      send_frame(4'h1, 4'h3, 16'hFFFF, 1'b0);
      @(negedge clk); par_dv_i = 1'b0;
      checks++;
      if ({frm_good_o, frm_bad_o, frm_abort_o} !== 3'b010) begin
         failures++; $display("FAIL bad_strobe got=%b exp=010", {frm_good_o, frm_bad_o, frm_abort_o});
      end
      checks++;
      if (cnt_chk_o !== 16'd1 || cnt_frm_o !== 16'd1) begin
         failures++; $display("FAIL bad_counters got=chk%0d/frm%0d exp=chk1/frm1", cnt_chk_o, cnt_frm_o);
      end
   endtask

   task automatic test_sequence();
      do_reset();
      pay_q = '{16'h0010, 16'h0020};
      send_frame(4'h2, 4'h2, 16'h0, 1'b0);
      idle(2);
      send_frame(4'h2, 4'h4, 16'h0, 1'b0);
      @(negedge clk); par_dv_i = 1'b0;
      checks++;
      if (frm_good_o !== 1'b1 || cnt_seq_o !== 16'd1 || cnt_frm_o !== 16'd2 || m_seq != 1) begin
         failures++; $display("FAIL seq_gap got=seq%0d/frm%0d exp=seq1/frm2", cnt_seq_o, cnt_frm_o);
      end
      do_reset();
      send_frame(4'h3, 4'h9, 16'h0, 1'b0);
      send_frame(4'h3, 4'hA, 16'h0, 1'b0);
      @(negedge clk); par_dv_i = 1'b0;
      checks++;
      if (cnt_seq_o !== 16'd0 || cnt_frm_o !== 16'd2) begin
         failures++; $display("FAIL seq_after_reset got=seq%0d/frm%0d exp=seq0/frm2", cnt_seq_o, cnt_frm_o);
      end
   endtask

   task automatic test_len_zero();
      logic [3:0] s;
      s = 4'(m_prev + 4'd1);
      drive(SOF);
      drive({4'h5, s, 8'h00});
      model_hdr(s);
      m_err++;
      @(negedge clk); par_dv_i = 1'b0;
      checks++;
      if ({frm_good_o, frm_bad_o, frm_abort_o} !== 3'b001 || cnt_err_o !== 16'(m_err)) begin
         failures++;
         $display("FAIL len0_abort got=%b/err%0d exp=001/err%0d", {frm_good_o, frm_bad_o, frm_abort_o}, cnt_err_o, m_err);
      end
      pay_q = '{16'h1111};
      send_frame(4'h5, 4'(m_prev + 4'd1), 16'h0, 1'b0);
      @(negedge clk); par_dv_i = 1'b0;
      checks++;
      if (frm_good_o !== 1'b1 || out_type_o !== 4'h5) begin
         failures++; $display("FAIL len0_next_frame got=%b/%h exp=1/5", frm_good_o, out_type_o);
      end
   endtask

   task automatic test_idle_words();
      drive(16'h0000); drive(16'h00FF); drive(16'h1234);
      idle(3);
      checks++;
      if ({frm_good_o, frm_bad_o, frm_abort_o} !== 3'b000 || cnt_err_o !== 16'(m_err)) begin
         failures++; $display("FAIL idle_words got=%b/err%0d exp=000/err%0d", {frm_good_o, frm_bad_o, frm_abort_o}, cnt_err_o, m_err);
      end
      pay_q = '{16'h00FF, 16'h0000};
      send_frame(4'h6, 4'(m_prev + 4'd1), 16'h0, 1'b0);
      @(negedge clk); par_dv_i = 1'b0;
      checks++;
      if (frm_good_o !== 1'b1) begin
         failures++; $display("FAIL idle_then_frame got=%b exp=1", frm_good_o);
      end
   endtask

   task automatic test_timeout();
      logic [3:0] s;
      int hit;
      logic saw_last;
      s = 4'(m_prev + 4'd1);
      drive(SOF);
      drive({4'h7, s, 8'd3});
      model_hdr(s);
      exp_q.push_back({1'b0, 16'hBEEF});
      drive(16'hBEEF);
      @(negedge clk); par_dv_i = 1'b0;
      hit = 0; saw_last = 1'b0;
      for (int k = 1; k <= TMO + 8; k++) begin
         if (k > 1) @(negedge clk);
         if (frm_abort_o === 1'b1 && hit == 0) hit = k;
         if (out_last_o === 1'b1) saw_last = 1'b1;
      end
      m_err++;
      checks++;
      if (hit != TMO + 1) begin
         failures++; $display("FAIL timeout_cycle got=%0d exp=%0d", hit, TMO + 1);
      end
      checks++;
      if (saw_last !== 1'b0 || cnt_err_o !== 16'(m_err)) begin
         failures++; $display("FAIL timeout_effects got=last%b/err%0d exp=last0/err%0d", saw_last, cnt_err_o, m_err);
      end
      pay_q = '{SOF, 16'h0042, SOF};
      send_frame(4'h8, 4'(m_prev + 4'd1), 16'h0, 1'b0);
      @(negedge clk); par_dv_i = 1'b0;
      checks++;
      if (frm_good_o !== 1'b1 || cnt_frm_o !== 16'(m_frm)) begin
         failures++; $display("FAIL sof_as_data got=%b/frm%0d exp=1/frm%0d", frm_good_o, cnt_frm_o, m_frm);
      end
   endtask

   task automatic test_disable();
      logic [3:0] s;
      logic bad;
      s = 4'(m_prev + 4'd1);
      drive(SOF);
      drive({4'h9, s, 8'd4});
      model_hdr(s);
      exp_q.push_back({1'b0, 16'h0101});
      drive(16'h0101);
      @(negedge clk);
      cfg_en_i = 1'b0; par_dv_i = 1'b1; par_dat_i = 16'h0202;
      m_armed = 1'b0;
      bad = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         par_dat_i = 16'h0303 + 16'(k);
         if ({out_dv_o, frm_good_o, frm_bad_o, frm_abort_o} !== 4'b0) bad = 1'b1;
      end
      par_dv_i = 1'b0;
      checks++;
      if (bad || {cnt_frm_o, cnt_chk_o, cnt_seq_o, cnt_err_o} !== {16'(m_frm), 16'(m_chk), 16'(m_seq), 16'(m_err)}) begin
         failures++; $display("FAIL disable_drop got=bad%b/%h exp=bad0/%h", bad,
            {cnt_frm_o, cnt_chk_o, cnt_seq_o, cnt_err_o}, {16'(m_frm), 16'(m_chk), 16'(m_seq), 16'(m_err)});
      end
      @(negedge clk); cfg_en_i = 1'b1;
      pay_q = '{16'h0A0A};
      send_frame(4'hA, 4'(m_prev + 4'd7), 16'h0, 1'b0);
      @(negedge clk); par_dv_i = 1'b0;
      checks++;
      if (frm_good_o !== 1'b1 || cnt_seq_o !== 16'(m_seq)) begin
         failures++; $display("FAIL reenable_exempt got=%b/seq%0d exp=1/seq%0d", frm_good_o, cnt_seq_o, m_seq);
      end
   endtask

   task automatic test_clear_wins();
      pay_q = '{16'h0007, 16'h0008};
      send_frame(4'hB, 4'(m_prev + 4'd1), 16'h0, 1'b1);
      @(negedge clk); par_dv_i = 1'b0; cnt_clr_i = 1'b0;
      checks++;
      if (frm_good_o !== 1'b1 || {cnt_frm_o, cnt_chk_o, cnt_seq_o, cnt_err_o} !== 64'h0) begin
         failures++; $display("FAIL clear_wins got=%b/%h exp=1/0", frm_good_o, {cnt_frm_o, cnt_chk_o, cnt_seq_o, cnt_err_o});
      end
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 4; f++) begin
         int n;
         n = $urandom_range(1, 8);
         pay_q.delete();
         for (int i = 0; i < n; i++) pay_q.push_back(16'($urandom));
         send_frame(4'(f), 4'(m_prev + 4'd1), (f == 2) ? 16'h0100 : 16'h0, 1'b0);
      end
      idle(2);
      checks++;
      if (cnt_frm_o !== 16'(m_frm) || cnt_chk_o !== 16'(m_chk) || cnt_seq_o !== 16'(m_seq)) begin
         failures++; $display("FAIL back_to_back got=frm%0d/chk%0d/seq%0d exp=frm%0d/chk%0d/seq%0d",
                              cnt_frm_o, cnt_chk_o, cnt_seq_o, m_frm, m_chk, m_seq);
      end
   endtask

   task automatic test_saturation();
      @(negedge clk); sc_rst = 1'b0; sc_inc = 1'b1;
      repeat (100) @(negedge clk);
      checks++;
      if (sc_cnt !== 8'd100) begin
         failures++; $display("FAIL sat_count got=%0d exp=100", sc_cnt);
      end
      repeat (200) @(negedge clk);
      checks++;
      if (sc_cnt !== 8'hFF) begin
         failures++; $display("FAIL sat_hold got=%0d exp=255", sc_cnt);
      end
      sc_clr = 1'b1;
      @(negedge clk);
      checks++;
      if (sc_cnt !== 8'd0) begin
         failures++; $display("FAIL sat_clr_wins got=%0d exp=0", sc_cnt);
      end
      sc_clr = 1'b0; sc_inc = 1'b0;
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_sequence();
      test_len_zero();
      test_idle_words();
      test_timeout();
      test_disable();
      test_clear_wins();
      test_back_to_back();
      test_saturation();
      idle(3);
      checks++;
      if (exp_q.size() != 0) begin
         failures++; $display("FAIL payload_missing got=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
